uart_rx_frame_dma: RTL and testbench

Parametrised frame-delimiting receive buffer between the UART byte receiver and user logic. It stores incoming words in an internal circular buffer and closes a frame when the line has been idle for a programmable gap. Complete frames are released on a ready/valid stream with a last marker. A frame that does not fit in the buffer is dropped whole, so user logic never sees a truncated frame.

---
 rtl/uart_dma_pkg.sv | 7 +
 rtl/uart_dma_ram.sv | 22 ++
 rtl/uart_rx_frame_dma.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame_dma.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_dma_pkg.sv
// uart_dma_pkg: shared write-FSM state type and gap-length helper for uart_rx_frame_dma
package uart_dma_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_e;
  function automatic int lp_gap(input int clk_freq, input int baud, input int gap_bits, input int gap_margin);
    return clk_freq / baud * gap_bits + gap_margin;
  endfunction
endpackage

// File: rtl/uart_dma_ram.sv
// uart_dma_ram: simple dual-port RAM, one write port, registered 1-cycle read port
module uart_dma_ram #(
  parameter int W = 9,
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end
  assign o_rdata = rdata_q;
endmodule

// File: rtl/uart_rx_frame_dma.sv
// uart_rx_frame_dma: idle-gap framed receive buffer; oversize frames dropped whole.
// Define UART_RX_DMA_STAT_EN to add saturating frame/drop counters.
module uart_rx_frame_dma
  import uart_dma_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int GAP_BITS   = 15,
  parameter int GAP_MARGIN = 50,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [DATA_W-1:0] o_user_rx_data,
  output logic              o_user_rx_valid,
  output logic              o_user_rx_last,
  input  logic              i_user_rx_ready,
  output logic              o_overflow
`ifdef UART_RX_DMA_STAT_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt
`endif
);
  localparam int LP_GAP = lp_gap(CLK_FREQ, BAUD, GAP_BITS, GAP_MARGIN);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(LP_GAP) + 1;
  wr_state_e state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, od_q, od_d;
  logic hold_v_q, hold_v_d, ovf_q, ovf_d, r1_v_q, r1_v_d, ov_q, ov_d, ol_q, ol_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, used;
  logic we, wlast, commit, gap_exp, room, adv, issue;
  logic [DATA_W:0] rdata;
  uart_dma_ram #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk  (i_clk),
    .i_we   (we),
    .i_waddr(wr_q[AW-1:0]),
    .i_wdata({wlast, hold_q}),
    .i_re   (issue),
    .i_raddr(rd_q[AW-1:0]),
    .o_rdata(rdata)
  );
  // Output stage: stage 1 is the RAM read register, stage 2 the output register.
  always_comb begin
    adv    = !ov_q || i_user_rx_ready;
    issue  = (rd_q != cm_q) && (!r1_v_q || adv);
    rd_d   = rd_q + (AW+1)'(issue);
    r1_v_d = issue || (r1_v_q && !adv);
    ov_d   = adv ? r1_v_q : ov_q;
    od_d   = (adv && r1_v_q) ? rdata[DATA_W-1:0] : od_q;
    ol_d   = (adv && r1_v_q) ? rdata[DATA_W] : ol_q;
  end
  // A read this cycle frees its slot for a write in the same cycle.
  always_comb begin
    used     = wr_q - rd_d;
    room     = used < (AW+1)'(DEPTH);
    gap_exp  = !i_rx_valid && (gap_q == GW'(LP_GAP - 1));
    gap_d    = i_rx_valid ? '0 : (gap_q == GW'(LP_GAP - 1)) ? gap_q : gap_q + GW'(1);
    state_d  = state_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    wr_d     = wr_q;
    cm_d     = cm_q;
    ovf_d    = 1'b0;
    we       = 1'b0;
    wlast    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: if (i_rx_valid) begin
        hold_d   = i_rx_data;
        hold_v_d = 1'b1;
        state_d  = RECV;
      end
      RECV: if (i_rx_valid) begin
        if (room) begin
          we     = 1'b1;
          wr_d   = wr_q + (AW+1)'(1);
          hold_d = i_rx_data;
        end else begin
          wr_d     = cm_q;
          hold_v_d = 1'b0;
          ovf_d    = 1'b1;
          state_d  = DROP;
        end
      end else if (gap_exp) begin
        hold_v_d = 1'b0;
        state_d  = IDLE;
        if (room) begin
          we     = 1'b1;
          wlast  = 1'b1;
          wr_d   = wr_q + (AW+1)'(1);
          cm_d   = wr_q + (AW+1)'(1);
          commit = 1'b1;
        end else begin
          wr_d  = cm_q;
          ovf_d = 1'b1;
        end
      end
      DROP: if (gap_exp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      gap_q    <= '0;
      wr_q     <= '0;
      cm_q     <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
      r1_v_q   <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ol_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      gap_q    <= gap_d;
      wr_q     <= wr_d;
      cm_q     <= cm_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
      r1_v_q   <= r1_v_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      ol_q     <= ol_d;
    end
  end
  assign o_user_rx_data  = od_q;
  assign o_user_rx_valid = ov_q;
  assign o_user_rx_last  = ol_q;
  assign o_overflow      = ovf_q;
`ifdef UART_RX_DMA_STAT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  always_comb begin
    frame_cnt_d = (commit && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = (ovf_d && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_frame_dma.sv
// tb_uart_rx_frame_dma: directed bench; DEPTH=8 instance for streaming, DEPTH=4 instance for overflow
module tb_uart_rx_frame_dma;
  // 20/10*15+4 with 2 clocks per bit, so one 10-bit byte slot is 20 clocks
  localparam int LP_GAP = 34;
  typedef struct packed {logic l; logic [7:0] d; logic [31:0] c;} beat_t;
  logic clk = 0, rst_n = 0, rxv = 0, rdy = 1;
  logic [7:0] rxd = 0;
  logic [7:0] od, od4;
  logic ov, ol, ovf, ov4, ol4, ovf4;
  beat_t q[$], q4[$];
  int errors = 0, checks = 0, n = 0, first_v = -1, strobe = 0, ovf_n = 0, ovf4_n = 0;
  logic tog = 0, prev_stall = 0, prev_l = 0;
  logic [7:0] prev_d = 0;
  logic [8:0] e[$];

  always #5 clk = ~clk;

  uart_rx_frame_dma #(.CLK_FREQ(20), .BAUD(10), .GAP_BITS(15), .GAP_MARGIN(4), .DATA_W(8), .DEPTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rxd), .i_rx_valid(rxv),
    .o_user_rx_data(od), .o_user_rx_valid(ov), .o_user_rx_last(ol),
    .i_user_rx_ready(rdy), .o_overflow(ovf)
  );
  uart_rx_frame_dma #(.CLK_FREQ(20), .BAUD(10), .GAP_BITS(15), .GAP_MARGIN(4), .DATA_W(8), .DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rxd), .i_rx_valid(rxv),
    .o_user_rx_data(od4), .o_user_rx_valid(ov4), .o_user_rx_last(ol4),
    .i_user_rx_ready(1'b1), .o_overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    if (tog) rdy = !rdy;
    #1;
    n++;
    if (rst_n && prev_stall) begin
      check("stall_valid", ov, 1);
      check("stall_data", od, prev_d);
      check("stall_last", ol, prev_l);
    end
    prev_stall = ov && !rdy && rst_n;
    prev_d = od;
    prev_l = ol;
    if (ov && rdy) q.push_back('{ol, od, n});
    if (ov4) q4.push_back('{ol4, od4, n});
    if (ovf) ovf_n++;
    if (ovf4) ovf4_n++;
    if (ov && first_v < 0) first_v = n;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc();
  endtask

  task automatic send(input logic [7:0] b);
    rxv = 1;
    rxd = b;
    strobe = n + 1;
    cyc();
    rxv = 0;
  endtask

  task automatic chk_beats(input string tag, input beat_t got[$], input logic [8:0] exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    foreach (exp[i])
      check($sformatf("%s_beat%0d", tag, i), i < got.size() ? {got[i].l, got[i].d} : 9'h1ff, exp[i]);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_valid"}, ov, 0);
    check({tag, "_last"}, ol, 0);
    check({tag, "_data"}, od, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_valid4"}, ov4, 0);
    check({tag, "_data4"}, od4, 0);
    check({tag, "_ovf4"}, ovf4, 0);
  endtask

  initial begin
    @(negedge clk);
    idle(3);
    chk_idle("reset");
    rst_n = 1;
    idle(2);

    // 3-byte burst at 10-bit spacing
    first_v = -1;
    send(8'h11); idle(19);
    send(8'h22); idle(19);
    send(8'h33); idle(50);
    e = '{9'h011, 9'h022, 9'h133};
    chk_beats("burst", q, e);
    check("burst_latency", first_v - (strobe + 1), LP_GAP + 2);
    q.delete();

    // 5-byte frame with ready toggling every cycle
    tog = 1;
    send(8'h51); idle(19);
    send(8'h52); idle(19);
    send(8'h53); idle(19);
    send(8'h54); idle(19);
    send(8'h55); idle(80);
    tog = 0;
    rdy = 1;
    idle(2);
    e = '{9'h051, 9'h052, 9'h053, 9'h054, 9'h155};
    chk_beats("bp", q, e);
    q.delete();

    // 6-byte frame overflows DEPTH=4, next 2-byte frame survives
    q4.delete();
    ovf_n = 0;
    ovf4_n = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'h61 + 8'(i));
      idle(19);
    end
    idle(21);
    send(8'hA0); idle(19);
    send(8'hA1); idle(50);
    check("ovf_pulses4", ovf4_n, 1);
    e = '{9'h0A0, 9'h1A1};
    chk_beats("ovf4", q4, e);
    check("ovf_pulses8", ovf_n, 0);
    check("depth8_count", q.size(), 8);
    q.delete();

    // back-to-back frames separated by exactly LP_GAP idle cycles, reader stalled
    rdy = 0;
    send(8'h71); idle(19);
    send(8'h72); idle(LP_GAP);
    send(8'h81); idle(19);
    send(8'h82); idle(50);
    check("b2b_stalled_valid", ov, 1);
    rdy = 1;
    idle(20);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_contig%0d", i), i < q.size() ? q[i].c - q[0].c : 0, i);
    e = '{9'h071, 9'h172, 9'h081, 9'h182};
    chk_beats("b2b", q, e);
    q.delete();

    // byte on the gap-expiry cycle is appended to the same frame
    send(8'h91); idle(LP_GAP - 1);
    send(8'h92); idle(50);
    e = '{9'h091, 9'h192};
    chk_beats("expiry", q, e);
    q.delete();

    // reset with a committed frame pending and a partial frame in flight
    rdy = 0;
    send(8'hC1); idle(40);
    check("pre_rst_valid", ov, 1);
    check("pre_rst_data", od, 8'hC1);
    send(8'hB1); idle(5);
    rst_n = 0;
    idle(2);
    chk_idle("midreset");
    rst_n = 1;
    rdy = 1;
    idle(60);
    check("post_rst_beats", q.size(), 0);
    check("post_rst_valid", ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
